// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The nibble width is fixed by the 4-bit adder datapath.
package nibble_serial_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_4b.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
// It serves as the per-nibble datapath of the serial adder.
module fa_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] c;

  // Each bit's carry feeds the next cell, from bit 0 up to bit 3.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that pushes one nibble per clock through a single
// 4-bit ripple adder, LSB nibble first, with valid/ready handshakes on both sides.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  import nibble_serial_pkg::*;

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_full;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_out_q;
  logic [CNT_W-1:0] cnt;
  logic [NIB_W-1:0] fa_s;
  logic             fa_co;

  fa_4b u_fa (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .c_in (carry_q),
    .s    (fa_s),
    .c_out(fa_co)
  );

  // New nibble enters at the top while older nibbles move down; this form
  // also degenerates cleanly to just fa_s when there is a single nibble.
  assign sum_full = WIDTH'({fa_s, sum_sh} >> NIB_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The visible result only updates on the final nibble, so sum/c_out stay
  // stable from one completed operation to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= c_in;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> NIB_W;
          b_sh    <= b_sh >> NIB_W;
          sum_sh  <= sum_full;
          carry_q <= fa_co;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q   <= sum_full;
            c_out_q <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule
